// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_HOLD,
        S_HALT
    } fetch_state_e;

    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs Wishbone classic reads, presents words to decode.
// Optional misaligned-redirect trap enabled by defining PC_CTRL_ALIGN_CHECK_EN.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = ADDR_WIDTH'(32'h8000_0000)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    redirect_i,
    input  logic [ADDR_WIDTH-1:0]   redirect_pc_i,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic                    wb_we_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    input  logic                    wb_ack_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic                    if_valid_o,
    input  logic                    if_ready_i,
    output logic [ADDR_WIDTH-1:0]   if_pc_o,
    output logic [DATA_WIDTH-1:0]   if_inst_o,
    output logic                    misalign_o,
    output logic [ADDR_WIDTH-1:0]   misalign_pc_o
);

    fetch_state_e          state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] fetch_pc_q;
    logic [DATA_WIDTH-1:0] inst_q;
    logic [ADDR_WIDTH-1:0] tgt;
    logic [ADDR_WIDTH-1:0] src;
    logic                  bad;
    logic                  halt_pend;

`ifdef PC_CTRL_ALIGN_CHECK_EN
    logic                  halt_pend_q;
    logic                  misalign_q;
    logic [ADDR_WIDTH-1:0] misalign_pc_q;

    assign tgt           = redirect_pc_i;
    assign bad           = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    assign halt_pend     = halt_pend_q;
    assign misalign_o    = misalign_q;
    assign misalign_pc_o = misalign_pc_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            halt_pend_q   <= 1'b0;
            misalign_q    <= 1'b0;
            misalign_pc_q <= '0;
        end else if (bad) begin
            halt_pend_q   <= 1'b1;
            misalign_q    <= 1'b1;
            misalign_pc_q <= redirect_pc_i;
        end else if (state_q == S_HALT && redirect_i) begin
            halt_pend_q   <= 1'b0;
            misalign_q    <= 1'b0;
        end
    end
`else
    logic unused_lsb;

    assign tgt           = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
    assign bad           = 1'b0;
    assign halt_pend     = 1'b0;
    assign misalign_o    = 1'b0;
    assign misalign_pc_o = '0;
    assign unused_lsb    = ^redirect_pc_i[1:0];
`endif

    assign src = redirect_i ? tgt : pc_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            pc_q       <= PC_ADDR;
            fetch_pc_q <= PC_ADDR;
            inst_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bad) begin
                        state_q <= S_HALT;
                    end else begin
                        fetch_pc_q <= src;
                        pc_q       <= src + ADDR_WIDTH'(PC_STEP);
                        state_q    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (wb_ack_i) begin
                        if (redirect_i) begin
                            pc_q    <= tgt;
                            state_q <= bad ? S_HALT : S_IDLE;
                        end else begin
                            inst_q  <= wb_dat_i;
                            state_q <= S_HOLD;
                        end
                    end else if (redirect_i) begin
                        pc_q    <= tgt;
                        state_q <= S_DRAIN;
                    end
                end
                // The outstanding read is never aborted; its data is simply dropped.
                S_DRAIN: begin
                    if (redirect_i) begin
                        pc_q <= tgt;
                    end
                    if (wb_ack_i) begin
                        state_q <= (halt_pend || bad) ? S_HALT : S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (redirect_i) begin
                        pc_q    <= tgt;
                        state_q <= bad ? S_HALT : S_IDLE;
                    end else if (if_ready_i) begin
                        fetch_pc_q <= src;
                        pc_q       <= src + ADDR_WIDTH'(PC_STEP);
                        state_q    <= S_FETCH;
                    end
                end
`ifdef PC_CTRL_ALIGN_CHECK_EN
                S_HALT: begin
                    if (redirect_i && !bad) begin
                        fetch_pc_q <= src;
                        pc_q       <= src + ADDR_WIDTH'(PC_STEP);
                        state_q    <= S_FETCH;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wb_cyc_o   = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign wb_stb_o   = wb_cyc_o;
    assign wb_adr_o   = wb_cyc_o ? fetch_pc_q : '0;
    assign wb_we_o    = 1'b0;
    assign wb_sel_o   = '1;
    assign if_valid_o = (state_q == S_HOLD);
    assign if_pc_o    = if_valid_o ? fetch_pc_q : '0;
    assign if_inst_o  = if_valid_o ? inst_q : '0;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl (default build and PC_CTRL_ALIGN_CHECK_EN build).
module tb_fetch_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i;
    logic [31:0] wb_dat_i;
    logic        if_valid_o, if_ready_i;
    logic [31:0] if_pc_o, if_inst_o;
    logic        misalign_o;
    logic [31:0] misalign_pc_o;

    int checks = 0;
    int errors = 0;

    fetch_ctrl #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .PC_ADDR    (32'h8000_0000)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .wb_cyc_o      (wb_cyc_o),
        .wb_stb_o      (wb_stb_o),
        .wb_adr_o      (wb_adr_o),
        .wb_we_o       (wb_we_o),
        .wb_sel_o      (wb_sel_o),
        .wb_ack_i      (wb_ack_i),
        .wb_dat_i      (wb_dat_i),
        .if_valid_o    (if_valid_o),
        .if_ready_i    (if_ready_i),
        .if_pc_o       (if_pc_o),
        .if_inst_o     (if_inst_o),
        .misalign_o    (misalign_o),
        .misalign_pc_o (misalign_pc_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        wb_ack_i = 1'b0; wb_dat_i = '0; if_ready_i = 1'b0;
        tick(); tick();
        checks++; if (wb_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %b want 0", wb_cyc_o); end
        checks++; if (wb_stb_o !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b want 0", wb_stb_o); end
        checks++; if (wb_adr_o !== 32'h0) begin errors++; $display("FAIL reset_adr: got %h want 0", wb_adr_o); end
        checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_valid_o); end
        checks++; if (if_pc_o !== 32'h0 || if_inst_o !== 32'h0) begin errors++; $display("FAIL reset_ifout: got %h/%h want 0/0", if_pc_o, if_inst_o); end
        checks++; if (misalign_o !== 1'b0 || misalign_pc_o !== 32'h0) begin errors++; $display("FAIL reset_misalign: got %b/%h want 0/0", misalign_o, misalign_pc_o); end
        checks++; if (wb_we_o !== 1'b0 || wb_sel_o !== 4'hF) begin errors++; $display("FAIL reset_we_sel: got %b/%h want 0/f", wb_we_o, wb_sel_o); end
    endtask

    task automatic test_sequential();
        logic [31:0] adrs [3];
        logic [31:0] dats [3];
        adrs = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008};
        dats = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113};
        if_ready_i = 1'b1;
        rst_ni = 1'b1;
        checks++; if (wb_cyc_o !== 1'b0) begin errors++; $display("FAIL first_edge_cyc: got %b want 0", wb_cyc_o); end
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (wb_cyc_o !== 1'b1 || wb_adr_o !== adrs[i]) begin errors++; $display("FAIL seq_adr[%0d]: got cyc=%b adr=%h want 1/%h", i, wb_cyc_o, wb_adr_o, adrs[i]); end
            tick();
            checks++; if (wb_cyc_o !== 1'b1 || if_valid_o !== 1'b0) begin errors++; $display("FAIL seq_wait[%0d]: got cyc=%b valid=%b want 1/0", i, wb_cyc_o, if_valid_o); end
            wb_ack_i = 1'b1; wb_dat_i = dats[i];
            tick();
            wb_ack_i = 1'b0; wb_dat_i = '0;
            checks++; if (if_valid_o !== 1'b1 || if_pc_o !== adrs[i] || if_inst_o !== dats[i]) begin errors++; $display("FAIL seq_present[%0d]: got v=%b pc=%h inst=%h want 1/%h/%h", i, if_valid_o, if_pc_o, if_inst_o, adrs[i], dats[i]); end
            checks++; if (wb_cyc_o !== 1'b0) begin errors++; $display("FAIL seq_gap[%0d]: got cyc=%b want 0", i, wb_cyc_o); end
            tick();
        end
    endtask

    task automatic test_stall();
        checks++; if (wb_cyc_o !== 1'b1 || wb_adr_o !== 32'h8000_000C) begin errors++; $display("FAIL stall_adr: got %b/%h want 1/8000000c", wb_cyc_o, wb_adr_o); end
        if_ready_i = 1'b0;
        wb_ack_i = 1'b1; wb_dat_i = 32'h0030_0193;
        tick();
        wb_ack_i = 1'b0; wb_dat_i = '0;
        for (int k = 0; k < 5; k++) begin
            checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h8000_000C || if_inst_o !== 32'h0030_0193 || wb_cyc_o !== 1'b0) begin
                errors++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h inst=%h cyc=%b want 1/8000000c/00300193/0", k, if_valid_o, if_pc_o, if_inst_o, wb_cyc_o);
            end
            tick();
        end
        if_ready_i = 1'b1;
        tick();
        checks++; if (wb_cyc_o !== 1'b1 || wb_adr_o !== 32'h8000_0010) begin errors++; $display("FAIL stall_resume: got %b/%h want 1/80000010", wb_cyc_o, wb_adr_o); end
    endtask

    task automatic test_redirect_drain();
        redirect_i = 1'b1; redirect_pc_i = 32'h8000_0100;
        tick();
        redirect_i = 1'b0; redirect_pc_i = '0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (wb_cyc_o !== 1'b1 || wb_adr_o !== 32'h8000_0010 || if_valid_o !== 1'b0) begin
                errors++; $display("FAIL drain_hold[%0d]: got cyc=%b adr=%h v=%b want 1/80000010/0", k, wb_cyc_o, wb_adr_o, if_valid_o);
            end
            if (k < 2) tick();
        end
        wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
        tick();
        wb_ack_i = 1'b0; wb_dat_i = '0;
        checks++; if (wb_cyc_o !== 1'b0 || if_valid_o !== 1'b0) begin errors++; $display("FAIL drain_idle: got cyc=%b v=%b want 0/0", wb_cyc_o, if_valid_o); end
        tick();
        checks++; if (wb_cyc_o !== 1'b1 || wb_adr_o !== 32'h8000_0100 || if_valid_o !== 1'b0) begin errors++; $display("FAIL drain_target: got cyc=%b adr=%h v=%b want 1/80000100/0", wb_cyc_o, wb_adr_o, if_valid_o); end
    endtask

    task automatic test_hold_redirect();
        wb_ack_i = 1'b1; wb_dat_i = 32'h00A0_0513;
        tick();
        wb_ack_i = 1'b0; wb_dat_i = '0;
        checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h8000_0100 || if_inst_o !== 32'h00A0_0513) begin errors++; $display("FAIL hold_present: got %b/%h/%h want 1/80000100/00a00513", if_valid_o, if_pc_o, if_inst_o); end
        redirect_i = 1'b1; redirect_pc_i = 32'h8000_0200;
        tick();
        redirect_i = 1'b0; redirect_pc_i = '0;
        checks++; if (if_valid_o !== 1'b0 || wb_cyc_o !== 1'b0) begin errors++; $display("FAIL hold_redirect_drop: got v=%b cyc=%b want 0/0", if_valid_o, wb_cyc_o); end
        tick();
        checks++; if (wb_cyc_o !== 1'b1 || wb_adr_o !== 32'h8000_0200) begin errors++; $display("FAIL hold_redirect_adr: got %b/%h want 1/80000200", wb_cyc_o, wb_adr_o); end
    endtask

    task automatic test_pc_wrap();
        wb_ack_i = 1'b1; wb_dat_i = 32'h0000_006F;
        tick();
        wb_ack_i = 1'b0; wb_dat_i = '0;
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        redirect_i = 1'b0; redirect_pc_i = '0;
        tick();
        checks++; if (wb_cyc_o !== 1'b1 || wb_adr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top: got %b/%h want 1/fffffffc", wb_cyc_o, wb_adr_o); end
        wb_ack_i = 1'b1; wb_dat_i = 32'h0000_0013;
        tick();
        wb_ack_i = 1'b0; wb_dat_i = '0;
        checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_present: got %b/%h want 1/fffffffc", if_valid_o, if_pc_o); end
        tick();
        checks++; if (wb_cyc_o !== 1'b1 || wb_adr_o !== 32'h0000_0000) begin errors++; $display("FAIL wrap_zero: got %b/%h want 1/00000000", wb_cyc_o, wb_adr_o); end
        wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
        redirect_i = 1'b1; redirect_pc_i = 32'h8000_0300;
        tick();
        wb_ack_i = 1'b0; wb_dat_i = '0;
        redirect_i = 1'b0; redirect_pc_i = '0;
        checks++; if (if_valid_o !== 1'b0 || wb_cyc_o !== 1'b0) begin errors++; $display("FAIL ack_redirect_drop: got v=%b cyc=%b want 0/0", if_valid_o, wb_cyc_o); end
        tick();
        checks++; if (wb_cyc_o !== 1'b1 || wb_adr_o !== 32'h8000_0300) begin errors++; $display("FAIL ack_redirect_adr: got %b/%h want 1/80000300", wb_cyc_o, wb_adr_o); end
    endtask

    task automatic test_reset_mid();
        tick();
        checks++; if (wb_cyc_o !== 1'b1) begin errors++; $display("FAIL midrst_pre: got cyc=%b want 1", wb_cyc_o); end
        rst_ni = 1'b0;
        #1;
        checks++; if (wb_cyc_o !== 1'b0 || wb_adr_o !== 32'h0 || if_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_async: got cyc=%b adr=%h v=%b want 0/0/0", wb_cyc_o, wb_adr_o, if_valid_o); end
        tick();
        rst_ni = 1'b1;
        checks++; if (wb_cyc_o !== 1'b0) begin errors++; $display("FAIL midrst_idle: got cyc=%b want 0", wb_cyc_o); end
        tick();
        checks++; if (wb_cyc_o !== 1'b1 || wb_adr_o !== 32'h8000_0000) begin errors++; $display("FAIL midrst_restart: got %b/%h want 1/80000000", wb_cyc_o, wb_adr_o); end
    endtask

    task automatic test_misalign();
`ifdef PC_CTRL_ALIGN_CHECK_EN
        redirect_i = 1'b1; redirect_pc_i = 32'h8000_0002;
        tick();
        redirect_i = 1'b0; redirect_pc_i = '0;
        checks++; if (misalign_o !== 1'b1 || misalign_pc_o !== 32'h8000_0002) begin errors++; $display("FAIL mis_flag: got %b/%h want 1/80000002", misalign_o, misalign_pc_o); end
        checks++; if (wb_cyc_o !== 1'b1 || wb_adr_o !== 32'h8000_0000) begin errors++; $display("FAIL mis_drain: got %b/%h want 1/80000000", wb_cyc_o, wb_adr_o); end
        wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
        tick();
        wb_ack_i = 1'b0; wb_dat_i = '0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (wb_cyc_o !== 1'b0 || if_valid_o !== 1'b0 || misalign_o !== 1'b1) begin
                errors++; $display("FAIL mis_halt[%0d]: got cyc=%b v=%b mis=%b want 0/0/1", k, wb_cyc_o, if_valid_o, misalign_o);
            end
            tick();
        end
        redirect_i = 1'b1; redirect_pc_i = 32'h8000_0010;
        tick();
        redirect_i = 1'b0; redirect_pc_i = '0;
        checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b want 0", misalign_o); end
        checks++; if (wb_cyc_o !== 1'b1 || wb_adr_o !== 32'h8000_0010) begin errors++; $display("FAIL mis_resume: got %b/%h want 1/80000010", wb_cyc_o, wb_adr_o); end
`else
        redirect_i = 1'b1; redirect_pc_i = 32'h8000_0012;
        tick();
        redirect_i = 1'b0; redirect_pc_i = '0;
        checks++; if (wb_cyc_o !== 1'b1 || misalign_o !== 1'b0) begin errors++; $display("FAIL noalign_drain: got cyc=%b mis=%b want 1/0", wb_cyc_o, misalign_o); end
        wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
        tick();
        wb_ack_i = 1'b0; wb_dat_i = '0;
        checks++; if (wb_cyc_o !== 1'b0) begin errors++; $display("FAIL noalign_idle: got cyc=%b want 0", wb_cyc_o); end
        tick();
        checks++; if (wb_cyc_o !== 1'b1 || wb_adr_o !== 32'h8000_0010) begin errors++; $display("FAIL noalign_adr: got %b/%h want 1/80000010", wb_cyc_o, wb_adr_o); end
        checks++; if (misalign_o !== 1'b0 || misalign_pc_o !== 32'h0) begin errors++; $display("FAIL noalign_tied: got %b/%h want 0/0", misalign_o, misalign_pc_o); end
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_drain();
        test_hold_redirect();
        test_pc_wrap();
        test_reset_mid();
        test_misalign();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
